// File: rtl/poly_eval_pkg.sv
// Shared types and defaults for the Horner polynomial evaluator.
package poly_eval_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEGREE = 2;
    localparam int DEF_ACC_W  = 16;

    function automatic int idx_w(input int degree);
        int w;
        w = $clog2(degree + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/poly_mac_step.sv
// One Horner step: next_acc = acc*x + coef, wrapping or clamping
// depending on SATURATE_EN.
module poly_mac_step #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] coef,
    output logic [ACC_W-1:0]  next_acc,
    output logic              sat
);

`ifdef SATURATE_EN
    localparam int FW = ACC_W + DATA_W + 1;

    logic [FW-1:0] full;

    // Full-width sum cannot wrap: acc*x < 2^(ACC_W+DATA_W), plus coef.
    assign full     = FW'(acc) * FW'(x) + FW'(coef);
    assign sat      = |full[FW-1:ACC_W];
    assign next_acc = sat ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    assign next_acc = acc * ACC_W'(x) + ACC_W'(coef);
    assign sat      = 1'b0;
`endif

endmodule

// File: rtl/poly_eval_mac.sv
// Horner polynomial evaluator on one shared MAC, valid/ready on both sides.
// Optional SATURATE_EN clamps to all-ones and flags overflow.
module poly_eval_mac
    import poly_eval_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEGREE = DEF_DEGREE,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_x,
    input  logic [(DEGREE+1)*DATA_W-1:0] in_coef,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             result,
    output logic                         overflow,
    output logic                         busy
);

    localparam int IW       = idx_w(DEGREE);
    localparam int IDX_INIT = (DEGREE > 0) ? DEGREE - 1 : 0;
    localparam int CW       = (DEGREE + 1) * DATA_W;

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] x_r;
    logic [CW-1:0]     coef_r;

    logic [DATA_W-1:0] coef_sel;
    logic [ACC_W-1:0]  step_acc;
    logic              step_sat;
    logic              ovf_n;
    logic [ACC_W-1:0]  acc_n;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_comb begin
        coef_sel = '0;
        coef_sel = coef_r[int'(idx)*DATA_W +: DATA_W];
    end

    poly_mac_step #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_step (
        .acc     (acc),
        .x       (x_r),
        .coef    (coef_sel),
        .next_acc(step_acc),
        .sat     (step_sat)
    );

    // Once saturated, the rest of the evaluation stays pinned at all-ones.
    assign ovf_n = overflow | step_sat;
    assign acc_n = ovf_n ? {ACC_W{1'b1}} : step_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            idx       <= '0;
            x_r       <= '0;
            coef_r    <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_r      <= in_x;
                        coef_r   <= in_coef;
                        overflow <= 1'b0;
                        if (DEGREE == 0) begin
                            result    <= ACC_W'(in_coef[DATA_W-1:0]);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            acc   <= ACC_W'(in_coef[DEGREE*DATA_W +: DATA_W]);
                            idx   <= IW'(IDX_INIT);
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc      <= acc_n;
                    overflow <= ovf_n;
                    idx      <= idx - 1'b1;
                    if (idx == '0) begin
                        result    <= acc_n;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_eval_mac.sv
// Scoreboard bench for poly_eval_mac: DEGREE=2 and DEGREE=0 instances.
module tb_poly_eval_mac;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_x = '0;
    logic [23:0] in_coef = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        overflow;
    logic        busy;

    logic        in_valid0 = 1'b0;
    logic        in_ready0;
    logic [7:0]  in_x0 = '0;
    logic [7:0]  in_coef0 = '0;
    logic        out_valid0;
    logic        out_ready0 = 1'b0;
    logic [15:0] result0;
    logic        overflow0;
    logic        busy0;

    int checks = 0;
    int failures = 0;

    logic [16:0] sb[$];

    always #5 clk = ~clk;

    poly_eval_mac #(.DATA_W(8), .DEGREE(2), .ACC_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_coef  (in_coef),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .overflow (overflow),
        .busy     (busy)
    );

    poly_eval_mac #(.DATA_W(8), .DEGREE(0), .ACC_W(16)) dut0 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid0),
        .in_ready (in_ready0),
        .in_x     (in_x0),
        .in_coef  (in_coef0),
        .out_valid(out_valid0),
        .out_ready(out_ready0),
        .result   (result0),
        .overflow (overflow0),
        .busy     (busy0)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] model(input logic [7:0] x,
                                          input logic [7:0] c2,
                                          input logic [7:0] c1,
                                          input logic [7:0] c0);
        logic [7:0]  c[2];
        logic [15:0] a;
        logic [24:0] full;
        logic        ov;
        c[0] = c1;
        c[1] = c0;
        a  = {8'd0, c2};
        ov = 1'b0;
        for (int k = 0; k < 2; k++) begin
            full = 25'(a) * 25'(x) + 25'(c[k]);
`ifdef SATURATE_EN
            if (ov || full > 25'd65535) begin
                ov = 1'b1;
                a  = 16'hffff;
            end else begin
                a = full[15:0];
            end
`else
            a = full[15:0];
`endif
        end
        return {ov, a};
    endfunction

    // Accept one operand set, wait for the result, compare against the queue.
    task automatic eval2(input string tag, input logic [7:0] x,
                         input logic [7:0] c2, input logic [7:0] c1,
                         input logic [7:0] c0, input logic [16:0] exp,
                         input bit handshake);
        int lat;
        logic [16:0] e;
        sb.push_back(exp);
        in_x     = x;
        in_coef  = {c2, c1, c0};
        in_valid = 1'b1;
        lat = 0;
        while (!in_ready && lat < 20) begin
            tick();
            lat++;
        end
        tick();
        in_valid = 1'b0;
        in_x     = ~x;
        in_coef  = ~{c2, c1, c0};
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_busy"}, busy, 1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_res"}, result, e[15:0]);
            chk({tag, "_ovf"}, overflow, e[16]);
        end
        if (handshake) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk({tag, "_idle"}, in_ready, 1);
        end
    endtask

    initial begin
        logic [15:0] held;
        logic [7:0]  rx, r2, r1, r0;
        int lat;

        tick();
        tick();
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_ovf", overflow, 0);

        eval2("basic", 8'd4, 8'd3, 8'd5, 8'd7, 17'd75, 1'b1);
        chk("basic_busy_after", busy, 0);

`ifdef SATURATE_EN
        eval2("max", 8'd255, 8'd255, 8'd255, 8'd255, {1'b1, 16'd65535}, 1'b1);
`else
        eval2("max", 8'd255, 8'd255, 8'd255, 8'd255, {1'b0, 16'd511}, 1'b1);
`endif
        eval2("xzero", 8'd0, 8'd9, 8'd9, 8'd42, 17'd42, 1'b1);
        eval2("xone", 8'd1, 8'd1, 8'd2, 8'd3, 17'd6, 1'b1);

        // Backpressure: result held, new operands ignored.
        eval2("bp", 8'd2, 8'd1, 8'd1, 8'd1, 17'd7, 1'b0);
        held = 16'd7;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_x     = 8'($urandom);
            in_coef  = 24'($urandom);
            tick();
            chk("bp_hold_res", result, held);
            chk("bp_hold_ready", in_ready, 0);
            chk("bp_hold_valid", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_ready", in_ready, 1);
        chk("bp_valid_drop", out_valid, 0);
        chk("bp_res_kept", result, held);
        tick();
        chk("bp_no_reaccept", busy, 0);

        // Reset one cycle after accept discards the evaluation.
        in_x     = 8'd3;
        in_coef  = {8'd1, 8'd1, 8'd1};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_res", result, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("mid_rst_quiet", out_valid, 0);
        eval2("after_rst", 8'd10, 8'd2, 8'd3, 8'd4, 17'd234, 1'b1);

        for (int i = 0; i < 8; i++) begin
            rx = 8'($urandom);
            r2 = 8'($urandom);
            r1 = 8'($urandom);
            r0 = 8'($urandom);
            eval2("rand", rx, r2, r1, r0, model(rx, r2, r1, r0), 1'b1);
        end

        // DEGREE=0 instance.
        in_coef0  = 8'd200;
        in_x0     = 8'd77;
        in_valid0 = 1'b1;
        chk("d0_ready", in_ready0, 1);
        tick();
        in_valid0 = 1'b0;
        in_coef0  = 8'd1;
        chk("d0_lat1", out_valid0, 1);
        lat = 1;
        while (!out_valid0 && lat < 20) begin
            tick();
            lat++;
        end
        chk("d0_res", result0, 200);
        chk("d0_ovf", overflow0, 0);
        chk("d0_busy", busy0, 1);
        out_ready0 = 1'b1;
        tick();
        out_ready0 = 1'b0;
        chk("d0_idle", in_ready0, 1);
        chk("d0_res_kept", result0, 200);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
